req_arbiter: RTL and testbench



---
 rtl/req_arbiter.sv | 85 ++++++++
 tb/tb_req_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/req_arbiter.sv
// N-way request/grant arbiter with a registered one-hot grant that is held while its owner requests.
// Fixed priority (bit 0 highest) by default; define ARBITER_ROUND_ROBIN_EN for round-robin selection.
module req_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] r,
    output logic [N-1:0] g
);

    logic [N-1:0] g_q, g_d;
    logic [N-1:0] win_onehot;
    logic         found;

`ifdef ARBITER_ROUND_ROBIN_EN
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] win_idx;
    logic [PW-1:0] cand;

    // Search starts just past the last winner and wraps, so every requester gets a turn.
    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        found      = 1'b0;
        cand       = '0;
        for (int k = 1; k <= N; k++) begin
            cand = PW'((int'(ptr_q) + k) % N);
            if (!found && r[cand]) begin
                found           = 1'b1;
                win_onehot[cand] = 1'b1;
                win_idx         = cand;
            end
        end
    end
`else
    always_comb begin
        win_onehot = '0;
        found      = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && r[i]) begin
                found         = 1'b1;
                win_onehot[i] = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        g_d = g_q;
`ifdef ARBITER_ROUND_ROBIN_EN
        ptr_d = ptr_q;
`endif
        if ((g_q & r) != '0) begin
            g_d = g_q;
        end else if (r == '0) begin
            g_d = '0;
        end else begin
            // Owner released (or idle) with others pending: hand over on this same edge.
            g_d = win_onehot;
`ifdef ARBITER_ROUND_ROBIN_EN
            ptr_d = win_idx;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            g_q <= '0;
`ifdef ARBITER_ROUND_ROBIN_EN
            ptr_q <= PW'(N - 1);
`endif
        end else begin
            g_q <= g_d;
`ifdef ARBITER_ROUND_ROBIN_EN
            ptr_q <= ptr_d;
`endif
        end
    end

    assign g = g_q;

endmodule

// File: tb/tb_req_arbiter.sv
// Bench for req_arbiter: index-level reference model checked every cycle plus literal expectations.
module tb_req_arbiter;

`ifdef ARBITER_ROUND_ROBIN_EN
  localparam int N = 4;
`else
  localparam int N = 2;
`endif

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] r   = '1;
  logic [N-1:0] g;

  always #5 clk = ~clk;

  req_arbiter #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .r   (r),
    .g   (g)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  // Tracks the owner as an index (-1 = nobody) and the last winner index.
  int m_own = -1;
  int m_ptr = N - 1;

  function automatic int pick(input logic [N-1:0] req, input int last);
`ifdef ARBITER_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N]) return (last + k) % N;
    end
`else
    for (int i = 0; i < N; i++) begin
      if (req[i]) return i;
    end
`endif
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_own = -1;
      m_ptr = N - 1;
    end else if (m_own >= 0 && r[m_own]) begin
      m_own = m_own;
    end else if (r == '0) begin
      m_own = -1;
    end else begin
      m_own = pick(r, m_ptr);
      m_ptr = m_own;
    end
  end

  function automatic logic [N-1:0] model_g();
    logic [N-1:0] v;
    v = '0;
    if (m_own >= 0) v[m_own] = 1'b1;
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: g=%b expected=%b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs mid-cycle, let one edge pass, then compare against the model.
  task automatic tick(input logic [N-1:0] rv, input logic rstv);
    @(negedge clk);
    r   = rv;
    rst = rstv;
    @(posedge clk);
    #1;
    check("model", g, model_g());
  endtask

  task automatic lit(input string name, input logic [N-1:0] exp);
    check(name, g, exp);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    for (int i = 0; i < 3; i++) begin
      tick('1, 1'b1);
      lit("reset_hold", '0);
    end

`ifdef ARBITER_ROUND_ROBIN_EN
    tick(4'b1111, 1'b0);
    lit("rr_first", 4'b0001);
    for (int i = 0; i < 3; i++) begin
      tick(4'b1111, 1'b0);
      lit("rr_lock", 4'b0001);
    end
    tick(4'b1110, 1'b0);
    lit("rr_turn1", 4'b0010);
    tick(4'b1101, 1'b0);
    lit("rr_turn2", 4'b0100);
    tick(4'b1011, 1'b0);
    lit("rr_turn3", 4'b1000);
    tick(4'b0111, 1'b0);
    lit("rr_wrap", 4'b0001);
    tick(4'b1110, 1'b0);
    lit("rr_turn1b", 4'b0010);
    tick(4'b1111, 1'b1);
    lit("rr_midrst", 4'b0000);
    tick(4'b1111, 1'b0);
    lit("rr_after_rst", 4'b0001);
    tick(4'b0000, 1'b0);
    lit("rr_idle", 4'b0000);
    tick(4'b0100, 1'b0);
    lit("rr_single", 4'b0100);
`else
    tick(2'b11, 1'b0);
    lit("rst_release", 2'b01);
    tick(2'b00, 1'b0);
    lit("idle", 2'b00);
    tick(2'b10, 1'b0);
    lit("single", 2'b10);
    tick(2'b00, 1'b0);
    lit("single_release", 2'b00);

    tick(2'b10, 1'b0);
    lit("lock_grant", 2'b10);
    for (int i = 0; i < 5; i++) begin
      tick(2'b11, 1'b0);
      lit("lock_hold", 2'b10);
    end
    tick(2'b01, 1'b0);
    lit("handoff", 2'b01);

    // Owner 0 keeps requesting; r[0] dips for one cycle after every 3 granted cycles.
    for (int round = 0; round < 2; round++) begin
      for (int i = 0; i < 3; i++) begin
        tick(2'b11, 1'b0);
        lit("cont_own0", 2'b01);
      end
      tick(2'b10, 1'b0);
      lit("cont_to1", 2'b10);
      tick(2'b11, 1'b0);
      lit("cont_hold1", 2'b10);
      tick(2'b01, 1'b0);
      lit("cont_back0", 2'b01);
    end

    tick(2'b10, 1'b0);
    lit("pre_rst_grant", 2'b10);
    tick(2'b11, 1'b1);
    lit("midrst", 2'b00);
    tick(2'b11, 1'b0);
    lit("after_rst", 2'b01);
`endif

    // A short random tail, checked against the model only.
    for (int i = 0; i < 40; i++) begin
      tick(N'($urandom_range(0, (1 << N) - 1)), ($urandom_range(0, 15) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
